// File: rtl/feistel_pkg.sv
// rtl/feistel_pkg.sv - shared widths, FSM states and key schedule for the Feistel cores
package feistel_pkg;

   localparam int BLOCK_W = 64;
   localparam int RKEY_W  = 32;
   localparam int MKEY_W  = 128;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Round key: one 32-bit master-key word chosen by r mod 4, whitened with r.
   function automatic logic [RKEY_W-1:0] round_key(input logic [MKEY_W-1:0] mkey,
                                                    input logic [7:0]        r);
      logic [RKEY_W-1:0] word;
      case (r[1:0])
         2'd0:    word = mkey[31:0];
         2'd1:    word = mkey[63:32];
         2'd2:    word = mkey[95:64];
         default: word = mkey[127:96];
      endcase
      return word ^ {{(RKEY_W-8){1'b0}}, r};
   endfunction

   function automatic logic [RKEY_W-1:0] f_mix(input logic [RKEY_W-1:0] x,
                                                input logic [RKEY_W-1:0] k);
      logic [RKEY_W-1:0] t;
      t = x ^ k;
      return {t[28:0], t[31:29]} + (t ^ 32'h9E3779B9);
   endfunction

endpackage

// File: rtl/feistel_dec_core_if.sv
// rtl/feistel_dec_core_if.sv - ciphertext-in / plaintext-out handshake bundle
interface feistel_dec_core_if;
   import feistel_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [BLOCK_W-1:0] in;
   logic [MKEY_W-1:0]  key;
   logic               out_valid;
   logic               out_ready;
   logic [BLOCK_W-1:0] out;

   modport master (output in_valid, in, key, out_ready,
                   input  in_ready, out_valid, out);

   modport slave  (input  in_valid, in, key, out_ready,
                   output in_ready, out_valid, out);

endinterface

// File: rtl/feistel_dec_core_ifcell.sv
// rtl/feistel_dec_core_ifcell.sv - combinational inverse Feistel round
module ifcell
   import feistel_pkg::*;
(
   input  logic [BLOCK_W-1:0] in,
   input  logic [RKEY_W-1:0]  key,
   output logic [BLOCK_W-1:0] out
);

   logic [RKEY_W-1:0] hi;
   logic [RKEY_W-1:0] lo;

   assign hi = in[BLOCK_W-1:RKEY_W];
   assign lo = in[RKEY_W-1:0];

   // Encrypt maps (L,R) to (R, L^F(R)); the upper half here is the old R.
   assign out = {lo ^ f_mix(hi, key), hi};

endmodule

// File: rtl/feistel_dec_core.sv
// rtl/feistel_dec_core.sv - iterative Feistel decryptor, one inverse round per clock
module feistel_dec_core
   import feistel_pkg::*;
#(
   parameter int ROUNDS = 16
)(
   input  logic               clk,
   input  logic               rst,
   feistel_dec_core_if.slave  bus
);

   localparam logic [7:0] R_LAST = 8'(ROUNDS - 1);

   state_t             state;
   state_t             state_nx;
   logic [BLOCK_W-1:0] data;
   logic [MKEY_W-1:0]  key_q;
   logic [7:0]         r;
   logic [RKEY_W-1:0]  rkey;
   logic [BLOCK_W-1:0] round_out;
   logic               in_ready_q;
   logic               out_valid_q;

   assign rkey = round_key(key_q, r);

   ifcell u_ifcell (
      .in  (data),
      .key (rkey),
      .out (round_out)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_nx = RUN;
         RUN:     if (r == 8'd0)     state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Handshake outputs are flopped from the next state so they never see input comb paths.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state       <= state_nx;
         in_ready_q  <= (state_nx == IDLE);
         out_valid_q <= (state_nx == DONE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data  <= '0;
         key_q <= '0;
         r     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  data  <= bus.in;
                  key_q <= bus.key;
                  r     <= R_LAST;
               end
            end
            RUN: begin
               data <= round_out;
               if (r != 8'd0) r <= r - 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out       = data;

endmodule

// File: tb/tb_feistel_dec_core.sv
// tb/tb_feistel_dec_core.sv - randomized self-checking bench for feistel_dec_core
module tb_feistel_dec_core;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   logic         in_valid_d [3];
   logic [63:0]  in_d       [3];
   logic [127:0] key_d      [3];
   logic         out_ready_d[3];
   logic         in_ready_o [3];
   logic         out_valid_o[3];
   logic [63:0]  out_o      [3];

   feistel_dec_core_if bus_r1 ();
   feistel_dec_core_if bus_r16 ();
   feistel_dec_core_if bus_r256 ();

   feistel_dec_core #(.ROUNDS(1))   dut_r1   (.clk(clk), .rst(rst), .bus(bus_r1.slave));
   feistel_dec_core #(.ROUNDS(16))  dut_r16  (.clk(clk), .rst(rst), .bus(bus_r16.slave));
   feistel_dec_core #(.ROUNDS(256)) dut_r256 (.clk(clk), .rst(rst), .bus(bus_r256.slave));

   assign bus_r1.in_valid    = in_valid_d[0];
   assign bus_r1.in          = in_d[0];
   assign bus_r1.key         = key_d[0];
   assign bus_r1.out_ready   = out_ready_d[0];
   assign in_ready_o[0]      = bus_r1.in_ready;
   assign out_valid_o[0]     = bus_r1.out_valid;
   assign out_o[0]           = bus_r1.out;

   assign bus_r16.in_valid   = in_valid_d[1];
   assign bus_r16.in         = in_d[1];
   assign bus_r16.key        = key_d[1];
   assign bus_r16.out_ready  = out_ready_d[1];
   assign in_ready_o[1]      = bus_r16.in_ready;
   assign out_valid_o[1]     = bus_r16.out_valid;
   assign out_o[1]           = bus_r16.out;

   assign bus_r256.in_valid  = in_valid_d[2];
   assign bus_r256.in        = in_d[2];
   assign bus_r256.key       = key_d[2];
   assign bus_r256.out_ready = out_ready_d[2];
   assign in_ready_o[2]      = bus_r256.in_ready;
   assign out_valid_o[2]     = bus_r256.out_valid;
   assign out_o[2]           = bus_r256.out;

   // Reference: forward Feistel encryption with round keys r = 0 .. rounds-1.
   function automatic logic [31:0] mix(input logic [31:0] x, input logic [31:0] k);
      logic [31:0] t;
      t = x ^ k;
      return ((t << 3) | (t >> 29)) + (t ^ 32'h9E3779B9);
   endfunction

   function automatic logic [63:0] encrypt(input logic [63:0] pt, input logic [127:0] mk,
                                           input int rounds);
      logic [31:0] l, rr, k, tmp;
      l  = pt[63:32];
      rr = pt[31:0];
      for (int i = 0; i < rounds; i++) begin
         k   = 32'(mk >> (32 * (i % 4))) ^ 32'(i);
         tmp = l ^ mix(rr, k);
         l   = rr;
         rr  = tmp;
      end
      return {l, rr};
   endfunction

   function automatic logic [127:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Called at a negedge with the selected core idle; returns the output and cycles from accept.
   task automatic run_block(input int sel, input logic [63:0] ct, input logic [127:0] mk,
                            output logic [63:0] pt, output int lat);
      in_d[sel]        = ct;
      key_d[sel]       = mk;
      in_valid_d[sel]  = 1'b1;
      out_ready_d[sel] = 1'b0;
      @(negedge clk);
      in_valid_d[sel]  = 1'b0;
      lat = 0;
      while (!out_valid_o[sel] && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      pt = out_o[sel];
      out_ready_d[sel] = 1'b1;
      @(negedge clk);
      out_ready_d[sel] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (in_ready_o[s] !== 1'b1) $display("FAIL reset_in_ready[%0d] got=%b exp=1", s, in_ready_o[s]);
         else passes++;
         checks++;
         if (out_valid_o[s] !== 1'b0) $display("FAIL reset_out_valid[%0d] got=%b exp=0", s, out_valid_o[s]);
         else passes++;
         checks++;
         if (out_o[s] !== 64'h0) $display("FAIL reset_out[%0d] got=%h exp=0", s, out_o[s]);
         else passes++;
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_round();
      logic [127:0] mk;
      logic [63:0]  ct, pt;
      int           lat;
      mk = {$urandom, $urandom, $urandom, 32'h01234567};
      ct = encrypt(64'hDEADBEEFBAADF00D, mk, 1);
      run_block(0, ct, mk, pt, lat);
      checks++;
      if (pt !== 64'hDEADBEEFBAADF00D) $display("FAIL single_round_out got=%h exp=deadbeefbaadf00d", pt);
      else passes++;
      checks++;
      if (lat !== 1) $display("FAIL single_round_latency got=%0d exp=1", lat);
      else passes++;
   endtask

   task automatic test_round_trip();
      logic [127:0] mk;
      logic [63:0]  src, pt;
      int           lat;
      mk = 128'h000102030405060708090A0B0C0D0E0F;
      for (int n = 0; n < 100; n++) begin
         src = {$urandom, $urandom};
         run_block(1, encrypt(src, mk, 16), mk, pt, lat);
         checks++;
         if (pt !== src) $display("FAIL round_trip_out[%0d] got=%h exp=%h", n, pt, src);
         else passes++;
         checks++;
         if (lat !== 16) $display("FAIL round_trip_latency[%0d] got=%0d exp=16", n, lat);
         else passes++;
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] mk;
      logic [63:0]  src;
      int           lat;
      mk  = rand_key();
      src = {$urandom, $urandom};
      in_d[1] = encrypt(src, mk, 16);
      key_d[1] = mk;
      in_valid_d[1] = 1'b1;
      out_ready_d[1] = 1'b0;
      @(negedge clk);
      in_valid_d[1] = 1'b0;
      lat = 0;
      while (!out_valid_o[1] && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      for (int c = 0; c < 20; c++) begin
         checks++;
         if (out_o[1] !== src) $display("FAIL bp_out_stable[%0d] got=%h exp=%h", c, out_o[1], src);
         else passes++;
         checks++;
         if (out_valid_o[1] !== 1'b1) $display("FAIL bp_out_valid[%0d] got=%b exp=1", c, out_valid_o[1]);
         else passes++;
         checks++;
         if (in_ready_o[1] !== 1'b0) $display("FAIL bp_in_ready[%0d] got=%b exp=0", c, in_ready_o[1]);
         else passes++;
         in_valid_d[1] = (c == 10);
         in_d[1] = {$urandom, $urandom};
         key_d[1] = rand_key();
         @(negedge clk);
      end
      in_valid_d[1] = 1'b0;
      out_ready_d[1] = 1'b1;
      @(negedge clk);
      out_ready_d[1] = 1'b0;
      checks++;
      if (in_ready_o[1] !== 1'b1) $display("FAIL bp_release_in_ready got=%b exp=1", in_ready_o[1]);
      else passes++;
      checks++;
      if (out_valid_o[1] !== 1'b0) $display("FAIL bp_release_out_valid got=%b exp=0", out_valid_o[1]);
      else passes++;
      @(negedge clk);
      checks++;
      if (out_valid_o[1] !== 1'b0 || in_ready_o[1] !== 1'b1)
         $display("FAIL bp_pulse_ignored got=valid%b/ready%b exp=valid0/ready1", out_valid_o[1], in_ready_o[1]);
      else passes++;
   endtask

   task automatic test_input_change();
      logic [127:0] mk;
      logic [63:0]  src;
      int           lat;
      mk  = rand_key();
      src = {$urandom, $urandom};
      in_d[1] = encrypt(src, mk, 16);
      key_d[1] = mk;
      in_valid_d[1] = 1'b1;
      out_ready_d[1] = 1'b0;
      @(negedge clk);
      lat = 0;
      while (!out_valid_o[1] && lat < 400) begin
         in_valid_d[1] = 1'($urandom);
         in_d[1] = {$urandom, $urandom};
         key_d[1] = rand_key();
         @(negedge clk);
         lat++;
      end
      in_valid_d[1] = 1'b0;
      checks++;
      if (out_o[1] !== src) $display("FAIL input_change_out got=%h exp=%h", out_o[1], src);
      else passes++;
      checks++;
      if (lat !== 16) $display("FAIL input_change_latency got=%0d exp=16", lat);
      else passes++;
      out_ready_d[1] = 1'b1;
      @(negedge clk);
      out_ready_d[1] = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [127:0] mk;
      logic [63:0]  src, pt;
      int           lat;
      mk = rand_key();
      in_d[1] = {$urandom, $urandom};
      key_d[1] = mk;
      in_valid_d[1] = 1'b1;
      @(negedge clk);
      in_valid_d[1] = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid_o[1] !== 1'b0) $display("FAIL mid_reset_out_valid got=%b exp=0", out_valid_o[1]);
      else passes++;
      checks++;
      if (in_ready_o[1] !== 1'b1) $display("FAIL mid_reset_in_ready got=%b exp=1", in_ready_o[1]);
      else passes++;
      checks++;
      if (out_o[1] !== 64'h0) $display("FAIL mid_reset_out got=%h exp=0", out_o[1]);
      else passes++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      src = {$urandom, $urandom};
      run_block(1, encrypt(src, mk, 16), mk, pt, lat);
      checks++;
      if (pt !== src) $display("FAIL after_reset_out got=%h exp=%h", pt, src);
      else passes++;
      checks++;
      if (lat !== 16) $display("FAIL after_reset_latency got=%0d exp=16", lat);
      else passes++;
   endtask

   task automatic test_max_rounds();
      logic [63:0] src, pt;
      int          lat;
      for (int n = 0; n < 2; n++) begin
         src = {$urandom, $urandom};
         run_block(2, encrypt(src, 128'h0, 256), 128'h0, pt, lat);
         checks++;
         if (pt !== src) $display("FAIL max_rounds_out[%0d] got=%h exp=%h", n, pt, src);
         else passes++;
         checks++;
         if (lat !== 256) $display("FAIL max_rounds_latency[%0d] got=%0d exp=256", n, lat);
         else passes++;
      end
   endtask

   initial begin
      for (int s = 0; s < 3; s++) begin
         in_valid_d[s]  = 1'b0;
         in_d[s]        = '0;
         key_d[s]       = '0;
         out_ready_d[s] = 1'b0;
      end
      test_reset();
      test_single_round();
      test_round_trip();
      test_backpressure();
      test_input_change();
      test_reset_mid_run();
      test_max_rounds();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/feistel_dec_core.md
# feistel_dec_core

Iterative multi-round Feistel block decryptor. It takes a 64-bit ciphertext and a 128-bit master key, applies ROUNDS inverse rounds one per clock using the existing combinational `ifcell`, and returns the 64-bit plaintext. It is the receive-side counterpart of the iterative encryptor, which applies `fcell` rounds in ascending round order with the same key schedule. It sits between the ciphertext input stream and the plaintext consumer, using valid/ready handshakes on both sides.

## Interface
- ROUNDS, 16, number of Feistel rounds; legal range 1..256.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous reset, active-high.
- IN_VALID  in  1  a ciphertext block and key are presented.
- IN_READY  out  1  the core accepts a block this cycle.
- IN  in  64  ciphertext block.
- KEY  in  128  master key; sampled only on accept.
- OUT_VALID  out  1  plaintext is available.
- OUT_READY  in  1  the consumer takes the plaintext this cycle.
- OUT  out  64  plaintext block.

## Operation
- Round key: RK(r) = KEY[32*(r mod 4) +: 32] XOR r, where r is zero-extended to 32 bits. The encryptor uses r = 0..ROUNDS-1; this block uses r = ROUNDS-1 down to 0.
- Each inverse round computes `data <= ifcell(IN=data, KEY=RK(r))`.
- FSM states:
  - IDLE: IN_READY=1. On IN_VALID, latch IN into data, latch KEY, set r=ROUNDS-1, go to RUN.
  - RUN: apply one inverse round with RK(r). If r==0, go to DONE; otherwise r <= r-1.
  - DONE: OUT_VALID=1 and OUT=data. On OUT_READY, go to IDLE.
- IN_READY=0 in RUN and DONE. IN and KEY are ignored there, so changes to the input during a run have no effect.
- OUT holds a stable value while OUT_VALID=1 until it is taken. Consumer backpressure can last any length.
- The round counter is 8 bits (ceil(log2(256))). With ROUNDS=256, r starts at 255 and does not wrap.
- ROUNDS=1 gives exactly one RUN cycle using RK(0) = KEY[31:0].
- Reset at any point, including mid-RUN or in DONE with OUT_VALID high:
  - FSM returns to IDLE immediately (asynchronously).
  - data, latched key and r clear to 0.
  - The in-flight block is discarded with no partial output.
- Reset values: IN_READY=1, OUT_VALID=0, OUT=64'h0.

## Timing
- Accept edge is t0, where IN_VALID & IN_READY.
- RUN occupies edges t1..t_ROUNDS.
- OUT_VALID rises after edge t_ROUNDS, i.e. ROUNDS cycles after accept.
- If OUT_READY is already high, the handoff happens at edge t_ROUNDS+1. IN_READY is high again from that edge.
- Peak throughput is one block per ROUNDS+2 cycles. There is no overlap between blocks.
- IN_READY depends only on state, never combinationally on IN_VALID. OUT_VALID depends only on state, never on OUT_READY.
- Only registered outputs are allowed. `ifcell` is the only combinational path, from data to data next-state.

## Structure
- Shared package `feistel_pkg` holds:
  - BLOCK_W=64, RKEY_W=32, MKEY_W=128.
  - The FSM state enum {IDLE, RUN, DONE}.
  - Function `round_key(mkey, r)`, which must be the same function the encryptor uses.
- Sub-module: a single instance of the existing `ifcell` (ports IN, KEY, OUT). No new sub-module.

## Test plan
- Single round: ROUNDS=1, KEY[31:0]=32'h01234567, IN=fcell(64'hDEADBEEFBAADF00D, 32'h01234567). Required: OUT=64'hDEADBEEFBAADF00D with OUT_VALID exactly 1 cycle after accept.
- Round trip: ROUNDS=16, KEY=128'h000102030405060708090A0B0C0D0E0F. Feed 100 random ciphertexts produced by a 16-round fcell reference model using RK(0..15). Required: every OUT equals the original plaintext, each at latency 16.
- Backpressure: hold OUT_READY=0 for 20 cycles after OUT_VALID. Required: OUT is stable, IN_READY=0, and a new IN_VALID pulse is ignored. After one OUT_READY cycle, IN_READY=1 on the next cycle.
- Input change mid-run: change IN and KEY every cycle during RUN. Required: result is identical to the undisturbed run.
- Reset mid-run: assert RST at RUN cycle 5 of 16. Required: OUT_VALID=0, IN_READY=1, OUT=0 immediately; the next block decrypts correctly.
- Max rounds: ROUNDS=256, all-zero key. Required: OUT_VALID after exactly 256 cycles, with OUT matching the reference model (checks counter width and the XOR-r schedule).
